// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, serialises loads/stores into byte transfers.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned      CMD_W   = 6,
  parameter logic [CMD_W-1:0] CMD_LB  = CMD_W'(10),
  parameter logic [CMD_W-1:0] CMD_LH  = CMD_W'(11),
  parameter logic [CMD_W-1:0] CMD_LW  = CMD_W'(12),
  parameter logic [CMD_W-1:0] CMD_LBU = CMD_W'(13),
  parameter logic [CMD_W-1:0] CMD_LHU = CMD_W'(14),
  parameter logic [CMD_W-1:0] CMD_SB  = CMD_W'(15),
  parameter logic [CMD_W-1:0] CMD_SH  = CMD_W'(16),
  parameter logic [CMD_W-1:0] CMD_SW  = CMD_W'(17)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [CMD_W-1:0] cmdtype_in,
  input  logic [4:0]       rsd_addr_in,
  input  logic [31:0]      rsd_data_in,
  input  logic             write_rsd_in,
  input  logic [31:0]      mem_addr_in,
  input  logic             mem_ack_in,
  input  logic [7:0]       mem_rdata_in,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [31:0]      mem_addr_out,
  output logic [7:0]       mem_wdata_out,
  output logic [4:0]       rsd_addr_out,
  output logic [31:0]      rsd_data_out,
  output logic             write_rsd_out,
  output logic             stall_req_out,
  output logic             misalign_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load, is_store, is_mem, misaligned;
  logic [1:0]  last_idx;
  logic [31:0] load_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_idx = '0;
    case (cmdtype_in)
      CMD_LB, CMD_LBU: begin is_load  = 1'b1; last_idx = 2'd0; end
      CMD_LH, CMD_LHU: begin is_load  = 1'b1; last_idx = 2'd1; end
      CMD_LW:          begin is_load  = 1'b1; last_idx = 2'd3; end
      CMD_SB:          begin is_store = 1'b1; last_idx = 2'd0; end
      CMD_SH:          begin is_store = 1'b1; last_idx = 2'd1; end
      CMD_SW:          begin is_store = 1'b1; last_idx = 2'd3; end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem &&
                      (((last_idx == 2'd1) && mem_addr_in[0]) ||
                       ((last_idx == 2'd3) && (mem_addr_in[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    load_data = buf_q;
    case (cmdtype_in)
      CMD_LB:  load_data = {{24{buf_q[7]}}, buf_q[7:0]};
      CMD_LH:  load_data = {{16{buf_q[15]}}, buf_q[15:0]};
      CMD_LBU: load_data = {24'b0, buf_q[7:0]};
      CMD_LHU: load_data = {16'b0, buf_q[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    rsd_addr_out  = '0;
    rsd_data_out  = '0;
    write_rsd_out = 1'b0;
    stall_req_out = 1'b0;
    misalign_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          misalign_out = 1'b1;
        end else if (is_mem) begin
          stall_req_out = 1'b1;
          if (rdy_in) begin
            state_d = ACCESS;
            idx_d   = '0;
            buf_d   = '0;
          end
        end else begin
          rsd_addr_out  = rsd_addr_in;
          rsd_data_out  = rsd_data_in;
          write_rsd_out = write_rsd_in;
        end
      end
      ACCESS: begin
        stall_req_out = 1'b1;
        mem_req_out   = 1'b1;
        mem_we_out    = is_store;
        mem_addr_out  = mem_addr_in + {30'b0, idx_q};
        mem_wdata_out = rsd_data_in[{idx_q, 3'b000} +: 8];
        if (rdy_in && mem_ack_in) begin
          if (is_load) buf_d[{idx_q, 3'b000} +: 8] = mem_rdata_in;
          if (idx_q == last_idx) state_d = DONE;
          else                   idx_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (is_load) begin
          rsd_addr_out  = rsd_addr_in;
          rsd_data_out  = load_data;
          write_rsd_out = write_rsd_in;
        end
        if (rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low while reset is asserted, even for combinational pass-through.
    if (!rst_in) begin
      mem_req_out   = 1'b0;
      mem_we_out    = 1'b0;
      mem_addr_out  = '0;
      mem_wdata_out = '0;
      rsd_addr_out  = '0;
      rsd_data_out  = '0;
      write_rsd_out = 1'b0;
      stall_req_out = 1'b0;
      misalign_out  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage plus hand-written reset/ready/misalign sequences.
module tb_mem_stage;

  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] LB  = 6'd10;
  localparam logic [5:0] LH  = 6'd11;
  localparam logic [5:0] LW  = 6'd12;
  localparam logic [5:0] LBU = 6'd13;
  localparam logic [5:0] LHU = 6'd14;
  localparam logic [5:0] SB  = 6'd15;
  localparam logic [5:0] SH  = 6'd16;
  localparam logic [5:0] SW  = 6'd17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [5:0]  cmd;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        wr;
  logic [31:0] addr;
  logic        ack;
  logic [7:0]  rdata;
  logic        req, we;
  logic [31:0] maddr;
  logic [7:0]  wdata;
  logic [4:0]  rd_o;
  logic [31:0] data_o;
  logic        wr_o, stall, mis;

  int nchecks = 0;
  int nerr    = 0;

  mem_stage #(.CMD_W(6)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .cmdtype_in(cmd),
    .rsd_addr_in(rd), .rsd_data_in(data), .write_rsd_in(wr),
    .mem_addr_in(addr), .mem_ack_in(ack), .mem_rdata_in(rdata),
    .mem_req_out(req), .mem_we_out(we), .mem_addr_out(maddr), .mem_wdata_out(wdata),
    .rsd_addr_out(rd_o), .rsd_data_out(data_o), .write_rsd_out(wr_o),
    .stall_req_out(stall), .misalign_out(mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        wr;
    int          nbytes;    // 0 = non-memory op
    int          delay;     // idle ACCESS cycles before each ack
    logic        is_store;
    logic [31:0] rbytes;    // byte i returned for transfer i
    logic [31:0] exp_data;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"},    32'(req),    32'd0);
    check({tag, " we"},     32'(we),     32'd0);
    check({tag, " maddr"},  maddr,       32'd0);
    check({tag, " wdata"},  32'(wdata),  32'd0);
    check({tag, " rd_o"},   32'(rd_o),   32'd0);
    check({tag, " data_o"}, data_o,      32'd0);
    check({tag, " wr_o"},   32'(wr_o),   32'd0);
    check({tag, " stall"},  32'(stall),  32'd0);
    check({tag, " mis"},    32'(mis),    32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    cmd = v.cmd; addr = v.addr; data = v.wdata; rd = v.rd; wr = v.wr; ack = 1'b0;
    #1;
    if (v.nbytes == 0) begin
      check("pass rd",    32'(rd_o),  32'(v.rd));
      check("pass data",  data_o,     v.exp_data);
      check("pass wr",    32'(wr_o),  32'(v.exp_wr));
      check("pass stall", 32'(stall), 32'd0);
      check("pass req",   32'(req),   32'd0);
      return;
    end
    check("idle stall", 32'(stall), 32'd1);
    check("idle req",   32'(req),   32'd0);
    check("idle wr_o",  32'(wr_o),  32'd0);
    for (int i = 0; i < v.nbytes; i++) begin
      for (int d = 0; d <= v.delay; d++) begin
        @(negedge clk);
        ack = 1'b0;
        #1;
        check("acc req",    32'(req),   32'd1);
        check("acc stall",  32'(stall), 32'd1);
        check("acc addr",   maddr,      v.addr + 32'(i));
        check("acc we",     32'(we),    32'(v.is_store));
        if (v.is_store) check("acc wdata", 32'(wdata), 32'(v.wdata[8*i +: 8]));
        check("acc bubble", data_o | 32'(wr_o), 32'd0);
        if (d == v.delay) begin
          ack   = 1'b1;
          rdata = v.rbytes[8*i +: 8];
        end
      end
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("done stall", 32'(stall), 32'd0);
    check("done req",   32'(req),   32'd0);
    check("done data",  data_o,     v.exp_data);
    check("done wr",    32'(wr_o),  32'(v.exp_wr));
    if (!v.is_store) check("done rd", 32'(rd_o), 32'(v.rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          cmd  addr          wdata         rd     wr    n  dly st    rbytes        exp_data      exp_wr
    vecs[0]  = '{ADD, 32'h0,        32'h0000_1234, 5'd5,  1'b1, 0, 0, 1'b0, 32'h0,        32'h0000_1234, 1'b1};
    vecs[1]  = '{LW,  32'h100,      32'h0,         5'd7,  1'b1, 4, 0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[2]  = '{LB,  32'h20,       32'h0,         5'd8,  1'b1, 1, 0, 1'b0, 32'h80,        32'hFFFF_FF80, 1'b1};
    vecs[3]  = '{LBU, 32'h20,       32'h0,         5'd8,  1'b1, 1, 0, 1'b0, 32'h80,        32'h0000_0080, 1'b1};
    vecs[4]  = '{SH,  32'h40,       32'hAABB_CCDD, 5'd2,  1'b1, 2, 3, 1'b1, 32'h0,        32'h0,         1'b0};
    vecs[5]  = '{LH,  32'h30,       32'h0,         5'd10, 1'b1, 2, 1, 1'b0, 32'h8001,      32'hFFFF_8001, 1'b1};
    vecs[6]  = '{LHU, 32'h30,       32'h0,         5'd11, 1'b1, 2, 0, 1'b0, 32'h8001,      32'h0000_8001, 1'b1};
    vecs[7]  = '{ADD, 32'h0,        32'hDEAD_BEEF, 5'd31, 1'b0, 0, 0, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{SW,  32'h50,       32'h1122_3344, 5'd3,  1'b1, 4, 1, 1'b1, 32'h0,        32'h0,         1'b0};
    vecs[9]  = '{SB,  32'hFFFF_FFFF, 32'h0000_005A, 5'd4, 1'b1, 1, 2, 1'b1, 32'h0,        32'h0,         1'b0};
    vecs[10] = '{LB,  32'h21,       32'h0,         5'd12, 1'b1, 1, 0, 1'b0, 32'h7F,        32'h0000_007F, 1'b1};
    vecs[11] = '{LW,  32'h104,      32'h0,         5'd13, 1'b0, 4, 0, 1'b0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0};
    vecs[12] = '{LHU, 32'h32,       32'h0,         5'd14, 1'b1, 2, 2, 1'b0, 32'hFFFF,      32'h0000_FFFF, 1'b1};

    rst_n = 1'b0; rdy = 1'b1; ack = 1'b0; rdata = '0;
    cmd = ADD; rd = 5'd5; data = 32'h1234; wr = 1'b1; addr = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) run_vec(vecs[k]);

    // rdy_in low: acks ignored and request held
    @(negedge clk);
    cmd = LB; addr = 32'h60; rd = 5'd3; wr = 1'b1; data = '0; ack = 1'b0;
    #1;
    check("rdy idle stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    check("rdy acc req", 32'(req), 32'd1);
    rdy = 1'b0; ack = 1'b1; rdata = 8'h11;
    @(negedge clk); #1;
    check("rdy hold req",  32'(req), 32'd1);
    check("rdy hold addr", maddr,    32'h60);
    @(negedge clk); #1;
    check("rdy hold2 req", 32'(req), 32'd1);
    rdy = 1'b1; ack = 1'b1; rdata = 8'h7F;
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("rdy done data",  data_o,      32'h0000_007F);
    check("rdy done wr",    32'(wr_o),   32'd1);
    check("rdy done stall", 32'(stall),  32'd0);

    // reset in the middle of a store at idx 2
    @(negedge clk);
    cmd = SW; addr = 32'h80; data = 32'hCAFE_F00D; rd = 5'd9; wr = 1'b1; ack = 1'b0;
    #1;
    check("rst idle stall", 32'(stall), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ack = 1'b0;
      #1;
      check("rst pre addr", maddr, 32'h80 + 32'(i));
      ack = 1'b1;
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    check("rst idx2 addr",  maddr,      32'h82);
    check("rst idx2 wdata", 32'(wdata), 32'hFE);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec('{SW, 32'h80, 32'hCAFE_F00D, 5'd9, 1'b1, 4, 0, 1'b1, 32'h0, 32'h0, 1'b0});

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    cmd = LW; addr = 32'h102; rd = 5'd6; wr = 1'b1; data = '0; ack = 1'b0;
    #1;
    check("mis pulse", 32'(mis),   32'd1);
    check("mis req",   32'(req),   32'd0);
    check("mis stall", 32'(stall), 32'd0);
    check("mis wr",    32'(wr_o),  32'd0);
    @(negedge clk);
    cmd = ADD; addr = '0;
    #1;
    check("mis after pulse", 32'(mis), 32'd0);
    check("mis after req",   32'(req), 32'd0);
`else
    run_vec('{LW, 32'h102, 32'h0, 5'd6, 1'b1, 4, 0, 1'b0, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b1});
    @(negedge clk); #1;
    check("nomis mis", 32'(mis), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
